// File: rtl/adder_tree_feeder.sv
// -----------------------------------------------------------------------------
// adder_tree_feeder
//
// Front/back-end wrapper around a fixed-latency pipelined adder tree.
// Products arrive one per handshake and are packed into a shadow buffer.
// When a full vector of N products is held, it is launched into the tree
// together with the bias captured at element 0. A TREE_LAT-deep delay line
// tracks each launch. When the matching tree result comes out, it is written
// into a small first-word-fall-through result FIFO. Credits reserve a FIFO
// slot for every vector at its first element, so the FIFO cannot overflow.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   GlobalReset  synchronous active-high reset
//   in_valid     product valid
//   in_ready     product accepted when in_valid && in_ready (registered)
//   in_data      product word
//   in_last      final product of a vector
//   in_beta      bias, sampled on the element-0 accept only
//   tree_vec     packed products, element k at [W*k +: W]
//   tree_beta    bias presented to the tree
//   tree_launch  one-cycle pulse, tree_vec/tree_beta valid in this cycle
//   tree_result  tree output, valid TREE_LAT cycles after tree_launch
//   res_valid    result FIFO not empty
//   res_data     result FIFO head (first-word fall-through)
//   res_ready    pop when res_valid && res_ready
//   err_framing  sticky in_last framing error
//   busy         partial vector held or any credit outstanding
// -----------------------------------------------------------------------------
module adder_tree_feeder #(
    parameter int N         = 14,
    parameter int W         = 26,
    parameter int TREE_LAT  = 8,
    parameter int RES_DEPTH = 4
) (
    input  logic           clk,
    input  logic           GlobalReset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic           in_last,
    input  logic [W-1:0]   in_beta,
    output logic [N*W-1:0] tree_vec,
    output logic [W-1:0]   tree_beta,
    output logic           tree_launch,
    input  logic [W-1:0]   tree_result,
    output logic           res_valid,
    output logic [W-1:0]   res_data,
    input  logic           res_ready,
    output logic           err_framing,
    output logic           busy
);

    localparam int IDX_W = $clog2(N);
    localparam int CRD_W = $clog2(RES_DEPTH + 1);
    localparam int PTR_W = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CRD_W-1:0]      credits_q, credits_d;
    logic                  in_ready_q, in_ready_d;
    logic                  err_q, err_d;
    logic [N-2:0][W-1:0]   shadow_q, shadow_d;
    logic [W-1:0]          beta_shadow_q, beta_shadow_d;
    logic [N*W-1:0]        tree_vec_q, tree_vec_d;
    logic [W-1:0]          tree_beta_q, tree_beta_d;
    logic                  tree_launch_q, tree_launch_d;
    logic [TREE_LAT-1:0]   lat_q, lat_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CRD_W-1:0]      count_q, count_d;
    logic [W-1:0]          fifo_mem [RES_DEPTH];

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic accept;
    logic at_first;
    logic at_last;
    logic launch;
    logic discard;
    logic reserve;
    logic push;
    logic pop;

    always_comb begin
        accept   = in_valid && in_ready_q;
        at_first = (idx_q == '0);
        at_last  = (idx_q == IDX_W'(N - 1));
        reserve  = accept && at_first;
        launch   = accept && at_last;
        // An early in_last drops the partial vector. When this happens on
        // element 0, the reserve and the release cancel out in the same cycle.
        discard  = accept && !at_last && in_last;
        push     = lat_q[TREE_LAT-1];
        pop      = (count_q != '0) && res_ready;
    end

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ------------------------------------------------------------------
    // Shadow buffer and launch packing. The last slot is never stored;
    // it is taken straight from in_data on the launching accept.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < N - 1; gi++) begin : g_slot
        assign shadow_d[gi] = (accept && idx_q == IDX_W'(gi)) ? in_data : shadow_q[gi];
        assign tree_vec_d[W*gi +: W] = launch ? shadow_q[gi] : tree_vec_q[W*gi +: W];
    end
    assign tree_vec_d[W*(N-1) +: W] = launch ? in_data : tree_vec_q[W*(N-1) +: W];

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        idx_d         = idx_q;
        err_d         = err_q;
        beta_shadow_d = reserve ? in_beta : beta_shadow_q;
        tree_beta_d   = launch ? beta_shadow_q : tree_beta_q;
        tree_launch_d = launch;

        if (accept) begin
            if (at_last || in_last) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + 1'b1;
            end
            // in_last must be set on exactly the final element.
            if (at_last != in_last) begin
                err_d = 1'b1;
            end
        end

        credits_d = credits_q + CRD_W'(reserve) - CRD_W'(discard) - CRD_W'(pop);

        // in_ready is computed from the next state so it can be registered.
        // A new vector may only start if a result slot can be reserved.
        in_ready_d = (idx_d != '0) || (credits_d < CRD_W'(RES_DEPTH));

        lat_d    = {lat_q[TREE_LAT-2:0], tree_launch_q};

        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q + CRD_W'(push) - CRD_W'(pop);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (GlobalReset) begin
            idx_q         <= '0;
            credits_q     <= '0;
            in_ready_q    <= 1'b0;
            err_q         <= 1'b0;
            shadow_q      <= '0;
            beta_shadow_q <= '0;
            tree_vec_q    <= '0;
            tree_beta_q   <= '0;
            tree_launch_q <= 1'b0;
            lat_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            idx_q         <= idx_d;
            credits_q     <= credits_d;
            in_ready_q    <= in_ready_d;
            err_q         <= err_d;
            shadow_q      <= shadow_d;
            beta_shadow_q <= beta_shadow_d;
            tree_vec_q    <= tree_vec_d;
            tree_beta_q   <= tree_beta_d;
            tree_launch_q <= tree_launch_d;
            lat_q         <= lat_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    // FIFO storage. It needs no reset because the pointers and count
    // define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !GlobalReset) begin
            fifo_mem[wr_ptr_q] <= tree_result;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready    = in_ready_q;
    assign tree_vec    = tree_vec_q;
    assign tree_beta   = tree_beta_q;
    assign tree_launch = tree_launch_q;
    assign res_valid   = (count_q != '0);
    // The head is forced to zero while the FIFO is empty, so res_data is 0
    // after reset even though the storage itself is not cleared.
    assign res_data    = (count_q != '0) ? fifo_mem[rd_ptr_q] : '0;
    assign err_framing = err_q;
    assign busy        = (idx_q != '0) || (credits_q != '0);

endmodule

// File: tb/tb_adder_tree_feeder.sv
module tb_adder_tree_feeder;

    localparam int N         = 14;
    localparam int W         = 26;
    localparam int TREE_LAT  = 8;
    localparam int RES_DEPTH = 4;

    logic           clk = 1'b0;
    logic           GlobalReset;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic [W-1:0]   in_beta;
    logic [N*W-1:0] tree_vec;
    logic [W-1:0]   tree_beta;
    logic           tree_launch;
    logic [W-1:0]   tree_result;
    logic           res_valid;
    logic [W-1:0]   res_data;
    logic           res_ready;
    logic           err_framing;
    logic           busy;

    adder_tree_feeder #(
        .N(N), .W(W), .TREE_LAT(TREE_LAT), .RES_DEPTH(RES_DEPTH)
    ) dut (
        .clk        (clk),
        .GlobalReset(GlobalReset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_beta    (in_beta),
        .tree_vec   (tree_vec),
        .tree_beta  (tree_beta),
        .tree_launch(tree_launch),
        .tree_result(tree_result),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .err_framing(err_framing),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Tree model: the sum of the vector and the bias, captured on launch and
    // delayed so that it is valid TREE_LAT cycles after the launch cycle.
    // Non-launch cycles carry a junk marker, so a mistimed capture shows up.
    logic [W-1:0] tree_sum;
    logic [W-1:0] pipe [TREE_LAT];

    always_comb begin
        tree_sum = tree_beta;
        for (int i = 0; i < N; i++) begin
            tree_sum = tree_sum + tree_vec[W*i +: W];
        end
    end

    initial begin
        for (int i = 0; i < TREE_LAT; i++) pipe[i] = 26'h2BADBAD;
    end

    always @(posedge clk) begin
        pipe[0] <= tree_launch ? tree_sum : 26'h2BADBAD;
        for (int i = 1; i < TREE_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign tree_result = pipe[TREE_LAT-1];

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int launches = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (tree_launch) launches++;
    endtask

    // Present one product and hold it until it is accepted. in_valid stays
    // high afterwards, so consecutive calls stream at full rate.
    task automatic send(input logic [W-1:0] d, input logic [W-1:0] b, input logic l);
        int t;
        in_valid = 1'b1;
        in_data  = d;
        in_beta  = b;
        in_last  = l;
        t = 0;
        while (!in_ready && t < 200) begin
            step();
            t++;
        end
        if (!in_ready) check("send_timeout", 64'd0, 64'd1);
        step();
    endtask

    task automatic pop_expect(input string tag, input logic [W-1:0] exp);
        int t;
        t = 0;
        while (!res_valid && t < 100) begin
            step();
            t++;
        end
        check({tag, "_valid"}, 64'(res_valid), 64'd1);
        check(tag, 64'(res_data), 64'(exp));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_vec"},    64'(tree_vec == '0), 64'd1);
        check({tag, "_beta"},   64'(tree_beta),      64'd0);
        check({tag, "_launch"}, 64'(tree_launch),    64'd0);
        check({tag, "_rvalid"}, 64'(res_valid),      64'd0);
        check({tag, "_rdata"},  64'(res_data),       64'd0);
        check({tag, "_err"},    64'(err_framing),    64'd0);
        check({tag, "_busy"},   64'(busy),           64'd0);
        check({tag, "_ready"},  64'(in_ready),       64'd0);
    endtask

    // Expected results for the back-pressure test: data=v on all 14 slots,
    // bias v<<12, so the result is 14*v + v*0x1000.
    logic [W-1:0] bp_exp [5] = '{26'h100E, 26'h201C, 26'h302A, 26'h4038, 26'h5046};

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lc;
        int stalls;
        int bad_iv;
        int seen;
        int lq[$];
        logic [W-1:0] rq[$];

        GlobalReset = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        in_last     = 1'b0;
        in_beta     = '0;
        res_ready   = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) step();
        check_all_zero("rst");
        GlobalReset = 1'b0;
        step();
        check("rst_ready_after", 64'(in_ready), 64'd1);

        // ---------------- T1: one clean vector ----------------
        for (int k = 0; k < N; k++) begin
            send(W'(k + 1), (k == 0) ? 26'h100 : 26'h3FF, k == N - 1);
        end
        in_valid = 1'b0;
        check("t1_launch", 64'(tree_launch), 64'd1);
        check("t1_beta", 64'(tree_beta), 64'h100);
        for (int k = 0; k < N; k++) begin
            check($sformatf("t1_slot%0d", k), 64'(tree_vec[W*k +: W]), 64'(k + 1));
        end
        check("t1_busy", 64'(busy), 64'd1);
        step();
        check("t1_launch_pulse", 64'(tree_launch), 64'd0);
        repeat (7) step();
        check("t1_not_early", 64'(res_valid), 64'd0);
        step();
        check("t1_rvalid_at_10", 64'(res_valid), 64'd1);
        check("t1_rdata", 64'(res_data), 64'h169);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t1_popped", 64'(res_valid), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // ---------------- T2: credit back-pressure ----------------
        for (int v = 1; v <= 4; v++) begin
            for (int k = 0; k < N; k++) begin
                send(W'(v), W'(v << 12), k == N - 1);
            end
        end
        in_valid = 1'b1;
        in_data  = W'(5);
        in_beta  = 26'h5000;
        in_last  = 1'b0;
        check("t2_ready_low", 64'(in_ready), 64'd0);
        check("t2_busy", 64'(busy), 64'd1);
        repeat (12) step();
        check("t2_still_stalled", 64'(in_ready), 64'd0);
        check("t2_head_valid", 64'(res_valid), 64'd1);
        check("t2_head", 64'(res_data), 64'(bp_exp[0]));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t2_ready_after_pop", 64'(in_ready), 64'd1);
        check("t2_next_head", 64'(res_data), 64'(bp_exp[1]));
        for (int k = 0; k < N; k++) begin
            send(W'(5), (k == 0) ? 26'h5000 : 26'h0, k == N - 1);
        end
        in_valid = 1'b0;
        for (int v = 1; v < 5; v++) begin
            pop_expect($sformatf("t2_order%0d", v), bp_exp[v]);
        end
        check("t2_drained", 64'(res_valid), 64'd0);
        check("t2_idle", 64'(busy), 64'd0);

        // ---------------- T3: early in_last ----------------
        lc = launches;
        for (int k = 0; k < 6; k++) begin
            send(26'h3FFFFFF, 26'h2, k == 5);
        end
        in_valid = 1'b0;
        check("t3_err", 64'(err_framing), 64'd1);
        check("t3_credit_back", 64'(busy), 64'd0);
        check("t3_ready", 64'(in_ready), 64'd1);
        repeat (2) step();
        check("t3_no_launch", 64'(launches - lc), 64'd0);
        for (int k = 0; k < N; k++) begin
            send(W'(k + 1), (k == 0) ? 26'h7 : 26'h0, k == N - 1);
        end
        in_valid = 1'b0;
        pop_expect("t3_clean", 26'h70);
        check("t3_err_sticky", 64'(err_framing), 64'd1);

        // ---------------- T4: missing in_last ----------------
        GlobalReset = 1'b1;
        step();
        GlobalReset = 1'b0;
        step();
        check("t4_err_cleared", 64'(err_framing), 64'd0);
        for (int k = 0; k < N; k++) begin
            send(W'(2), 26'h0, 1'b0);
        end
        in_valid = 1'b0;
        check("t4_err", 64'(err_framing), 64'd1);
        check("t4_launch", 64'(tree_launch), 64'd1);
        pop_expect("t4_result", 26'h1C);

        // ---------------- T5: full-rate streaming ----------------
        res_ready = 1'b1;
        stalls = 0;
        for (int v = 1; v <= 20; v++) begin
            for (int k = 0; k < N; k++) begin
                in_valid = 1'b1;
                in_data  = W'(v);
                in_beta  = 26'h0;
                in_last  = (k == N - 1);
                if (!in_ready) stalls++;
                step();
                if (tree_launch) lq.push_back(cyc);
                if (res_valid) rq.push_back(res_data);
            end
        end
        in_valid = 1'b0;
        repeat (14) begin
            step();
            if (tree_launch) lq.push_back(cyc);
            if (res_valid) rq.push_back(res_data);
        end
        res_ready = 1'b0;
        check("t5_no_stall", 64'(stalls), 64'd0);
        check("t5_launches", 64'(lq.size()), 64'd20);
        bad_iv = 0;
        for (int i = 1; i < lq.size(); i++) begin
            if (lq[i] - lq[i-1] != N) bad_iv++;
        end
        check("t5_launch_interval", 64'(bad_iv), 64'd0);
        check("t5_results", 64'(rq.size()), 64'd20);
        for (int i = 0; i < rq.size() && i < 20; i++) begin
            check($sformatf("t5_res%0d", i), 64'(rq[i]), 64'(14 * (i + 1)));
        end

        // ---------------- T6: reset with results queued ----------------
        for (int v = 1; v <= 3; v++) begin
            for (int k = 0; k < N; k++) begin
                send(W'(v), 26'h0, k == N - 1);
            end
        end
        in_valid = 1'b0;
        check("t6_launch", 64'(tree_launch), 64'd1);
        repeat (3) step();
        check("t6_queued", 64'(res_data), 64'hE);
        check("t6_busy", 64'(busy), 64'd1);
        GlobalReset = 1'b1;
        step();
        check_all_zero("t6_rst");
        GlobalReset = 1'b0;
        seen = 0;
        repeat (15) begin
            step();
            if (res_valid) seen++;
        end
        check("t6_inflight_dropped", 64'(seen), 64'd0);
        check("t6_idle", 64'(busy), 64'd0);
        check("t6_ready", 64'(in_ready), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_tree_feeder.md
Name: adder_tree_feeder

Overview:
- Front-end and back-end wrapper for the 14-input pipelined fixed-point adder tree.
- Accepts a stream of 26-bit weighted products, one per handshake, and packs N of them plus a bias into the tree's wide input vector, then issues a launch.
- Tracks the tree's fixed latency, captures each tree result into an output FIFO, and applies credit-based back-pressure so no result is ever lost.

Parameters:
- N, 14: products per vector (tree fan-in).
- W, 26: fixed-point word width.
- TREE_LAT, 8: cycles from the tree_launch cycle to the cycle in which tree_result is valid.
- RES_DEPTH, 4: output FIFO depth, equal to the maximum number of outstanding vectors.

Ports:
- clk  in  1  clock
- GlobalReset  in  1  synchronous, active-high reset
- in_valid  in  1  product valid
- in_ready  out  1  product accepted when in_valid && in_ready
- in_data  in  W  product word
- in_last  in  1  marks the final product of a vector
- in_beta  in  W  bias, sampled with the element-0 accept only
- tree_vec  out  N*W  packed products; element k at bits [W*k+W-1:W*k]
- tree_beta  out  W  bias for the tree
- tree_launch  out  1  one-cycle pulse; tree_vec/tree_beta are valid this cycle
- tree_result  in  W  tree output
- res_valid  out  1  FIFO not empty
- res_data  out  W  FIFO head (first-word fall-through)
- res_ready  in  1  pop when res_valid && res_ready
- err_framing  out  1  sticky in_last error flag
- busy  out  1  partial vector held, or credits_used != 0

Behaviour:
- Everything happens on the clk rising edge; GlobalReset is synchronous and active-high.
- Reset clears:
  - idx to 0 and credits_used to 0
  - the FIFO (empties it) and the latency delay line (in-flight results are dropped)
  - all outputs: tree_vec=0, tree_beta=0, tree_launch=0, res_valid=0, res_data=0, err_framing=0, busy=0
  - in_ready, which is 0 in the reset cycle.
- Reset asserted mid-vector or mid-flight discards everything; the first accept after reset is treated as element 0.
- Fill counter idx runs 0..N-1.
- in_ready rule:
  - idx==0: in_ready = (credits_used < RES_DEPTH).
  - idx!=0: in_ready = 1.
  - It is a registered or purely state-derived signal and never depends combinationally on in_valid.
- Accept at idx==0:
  - reserves one credit (credits_used+1)
  - captures in_beta into the shadow bias.
- Accept at idx=k: in_data is written to shadow slot k and idx increments.
- Accept at idx==N-1:
  - the next cycle, tree_vec is loaded from the shadow (slot N-1 taken from this accept), tree_beta is loaded, and tree_launch=1 for exactly one cycle
  - idx returns to 0
  - tree_vec/tree_beta hold until the next launch.
- Back-to-back vectors are allowed; a new element 0 may be accepted in the launch cycle.
- Framing errors (err_framing is cleared only by reset):
  - in_last=1 on an accept with idx<N-1: set err_framing, discard the partial vector, release its credit, set idx=0, no launch.
  - in_last=0 on the idx==N-1 accept: set err_framing; the vector still launches normally.
- Latency line:
  - A TREE_LAT-deep shift register carries tree_launch.
  - When its tap is 1, tree_result is pushed into the FIFO in that same cycle.
  - A pushed word is visible on res_data/res_valid the following cycle.
- Credits:
  - Released on a FIFO pop.
  - A reservation and a pop in the same cycle leave credits_used unchanged.
  - A discard and a pop in the same cycle decrement credits_used by 2.
  - credits_used ≤ RES_DEPTH always, so FIFO overflow is impossible.
  - A push into a full FIFO is a design error; verification asserts it never occurs.
- FIFO:
  - Circular, with wrap-around read/write pointers.
  - Simultaneous push and pop is legal at any occupancy, including empty-with-push (no bypass; the data appears the next cycle) and full-with-pop.
- Arithmetic: pure data movement, no width change; tree_result is stored verbatim.
- End-to-end latency, idx N-1 accept to res_valid: 1 + TREE_LAT + 1 = 10 cycles at defaults.

Test Plan:
- Reset, then 14 accepts of in_data=k+1 (k=0..13), in_beta=0x100 with element 0, in_last on k=13 -> tree_launch one cycle after the last accept; tree_vec slot k = k+1; tree_beta=0x100. With a bench tree model returning 105+0x100=0x169, res_data=0x169 ten cycles after the last accept.
- res_ready=0, stream 5 full vectors -> 4 vectors accepted; in_ready=0 at idx 0 of the 5th; credits_used=4. Pop one -> in_ready=1 next cycle; the 5th vector completes; FIFO order preserved.
- in_last on element 5 -> err_framing=1 sticky; no launch; credits_used returns to its prior value; the next 14 accepts form a clean vector.
- in_last=0 on element 13 -> err_framing=1, launch still occurs, result delivered.
- res_ready=1 with continuous input at full rate -> one launch every 14 cycles; FIFO occupancy ≤1; in_ready never drops; exercises push/pop in the same cycle and pointer wrap over 20 vectors.
- GlobalReset pulsed 3 cycles after a launch with 2 results queued -> all outputs 0 the next cycle; the dropped in-flight result is never pushed; busy=0.
